// File: rtl/seg7_scan_driver.sv
// Multi-digit seven-segment scan driver: prescaled digit scan, frame-synchronous commit, LZ blanking, PWM.
// Optional macro SEG7_DEADTIME_EN blanks segen during phase 0 of every slot (anti-ghosting).
module seg7_scan_driver #(
  parameter int DIGITS        = 4,
  parameter int SCAN_DIV_LOG2 = 16,
  parameter int BRIGHT_W      = 4,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     segen,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [SCAN_DIV_LOG2-1:0] r_cnt;
  logic [IDX_W-1:0]         r_idx;
  logic [4*DIGITS-1:0]      r_shadow_data;
  logic [DIGITS-1:0]        r_shadow_dp;
  logic [4*DIGITS-1:0]      r_disp_data;
  logic [DIGITS-1:0]        r_disp_dp;
  logic                     r_pending;
  logic                     r_valid;
  logic [6:0]               r_seg;
  logic                     r_dp;
  logic [DIGITS-1:0]        r_segen;
  logic                     r_frame_tick;

  logic                w_slot_tick;
  logic                w_frame_wrap;
  logic [BRIGHT_W-1:0] w_phase;
  logic                w_pwm_on;
  logic [3:0]          w_digit;
  logic [DIGITS:0]     w_hi_zero;
  logic [DIGITS-1:0]   w_blank_mask;
  logic                w_blank;
  logic [DIGITS-1:0]   w_onehot;
  logic [6:0]          w_seg_act;
  logic                w_dp_act;
  logic [DIGITS-1:0]   w_segen_act;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign w_slot_tick  = &r_cnt;
  assign w_frame_wrap = w_slot_tick && (r_idx == LAST_IDX);
  assign w_phase      = r_cnt[SCAN_DIV_LOG2-1 -: BRIGHT_W];

`ifdef SEG7_DEADTIME_EN
  assign w_pwm_on = (w_phase != '0) && (w_phase <= brightness);
`else
  assign w_pwm_on = (w_phase <= brightness);
`endif

  // w_hi_zero[k]: digit k and every digit above it are zero; digit 0 is never blankable.
  assign w_hi_zero[DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_lsd
        assign w_hi_zero[0] = 1'b0;
      end else begin : g_upper
        assign w_hi_zero[gi] = w_hi_zero[gi+1] && (r_disp_data[4*gi +: 4] == 4'h0);
      end
    end
  endgenerate

  assign w_blank_mask = w_hi_zero[DIGITS-1:0] & {DIGITS{blank_lz}};
  assign w_blank      = w_blank_mask[r_idx];
  assign w_digit      = r_disp_data[4*r_idx +: 4];
  assign w_onehot     = DIGITS'(1) << r_idx;

  assign w_seg_act   = r_valid ? f_decode(w_digit) : 7'd0;
  assign w_dp_act    = r_valid && r_disp_dp[r_idx] && !w_blank;
  assign w_segen_act = (r_valid && !w_blank && w_pwm_on) ? w_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_disp_data   <= '0;
      r_disp_dp     <= '0;
      r_pending     <= 1'b0;
      r_valid       <= 1'b0;
      r_seg         <= {7{ACTIVE_LOW}};
      r_dp          <= ACTIVE_LOW;
      r_segen       <= {DIGITS{ACTIVE_LOW}};
      r_frame_tick  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_frame_wrap) begin
        r_idx <= '0;
      end else if (w_slot_tick) begin
        r_idx <= r_idx + 1'b1;
      end

      // A load on the boundary cycle sets pending again, so it waits for the next boundary.
      if (load) begin
        r_shadow_data <= data;
        r_shadow_dp   <= dp_in;
        r_pending     <= 1'b1;
      end else if (w_frame_wrap) begin
        r_pending <= 1'b0;
      end

      if (w_frame_wrap && r_pending) begin
        r_disp_data <= r_shadow_data;
        r_disp_dp   <= r_shadow_dp;
        r_valid     <= 1'b1;
      end

      r_seg        <= w_seg_act ^ {7{ACTIVE_LOW}};
      r_dp         <= w_dp_act ^ ACTIVE_LOW;
      r_segen      <= w_segen_act ^ {DIGITS{ACTIVE_LOW}};
      r_frame_tick <= w_frame_wrap;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign segen      = r_segen;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, 16-cycle slots, BRIGHT_W=2), normal and active-low instances.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SA = 7'b1110111, SB = 7'b0011111;
  localparam logic [6:0] SC = 7'b1001110, SD = 7'b0111101, SE = 7'b1001111, SF = 7'b1000111;

`ifdef SEG7_DEADTIME_EN
  localparam bit DT = 1'b1;
`else
  localparam bit DT = 1'b0;
`endif

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dpi;
    logic            blz;
    logic [1:0]      br;
    logic [3:0][6:0] seg;
    logic [3:0]      lit;
    logic [3:0]      edp;
    int              on_n;
    int              on_dt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [1:0]  brightness;
  logic [6:0]  seg, seg_al;
  logic        dp, dp_al;
  logic [3:0]  segen, segen_al;
  logic        frame_tick, frame_tick_al;

  int n_cmp = 0;
  int n_err = 0;
  int pos   = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV_LOG2(4), .BRIGHT_W(2), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
    .brightness(brightness), .seg(seg), .dp(dp), .segen(segen), .frame_tick(frame_tick));

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV_LOG2(4), .BRIGHT_W(2), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
    .brightness(brightness), .seg(seg_al), .dp(dp_al), .segen(segen_al), .frame_tick(frame_tick_al));

  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] dpi, input logic blz,
                              input logic [1:0] br, input logic [27:0] segs, input logic [3:0] lit,
                              input logic [3:0] edp, input int on_n, input int on_dt);
    vec_t v;
    v.data = d; v.dpi = dpi; v.blz = blz; v.br = br; v.seg = segs;
    v.lit = lit; v.edp = edp; v.on_n = on_n; v.on_dt = on_dt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t pos=%0d: got %0h expected %0h", name, $time, pos, act, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 200);
    chk("frame_tick_seen", frame_tick, 1'b1);
    pos = 0;
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] dpi, input logic blz, input logic [1:0] br);
    data = d; dp_in = dpi; blank_lz = blz; brightness = br; load = 1'b1;
    adv(1);
    load = 1'b0;
  endtask

  task automatic check_frame(input vec_t v);
    int idx, ph, on_cnt, errs0;
    logic [3:0] exp_en;
    on_cnt = 0;
    errs0  = n_err;
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      idx = (j - 1) / 16;
      ph  = ((j - 1) % 16) / 4;
      exp_en = (v.lit[idx] && (ph <= int'(v.br)) && !(DT && ph == 0)) ? (4'b0001 << idx) : 4'b0000;
      chk("segen", segen, exp_en);
      if (v.lit[idx]) chk("seg", seg, v.seg[idx]);
      chk("dp", dp, v.edp[idx]);
      if (segen != 4'b0000) on_cnt++;
      if (j % 16 == 0) begin
        chk("on_cycles", on_cnt, v.lit[idx] ? (DT ? v.on_dt : v.on_n) : 0);
        on_cnt = 0;
      end
    end
    chk("frame_tick_period", frame_tick, 1'b1);
    pos = 0;
    $display("frame data=%h dp_in=%b blz=%0d br=%0d errors=%0d", v.data, v.dpi, v.blz, v.br, n_err - errs0);
  endtask

  initial begin
    int first_tick, n_zero_err;

    vecs[0] = mk(16'h1234, 4'b0000, 1'b0, 2'd3, {S1, S2, S3, S4}, 4'b1111, 4'b0000, 16, 12);
    vecs[1] = mk(16'hABCD, 4'b0101, 1'b0, 2'd1, {SA, SB, SC, SD}, 4'b1111, 4'b0101, 8, 4);
    vecs[2] = mk(16'h0040, 4'b1111, 1'b1, 2'd3, {S0, S0, S4, S0}, 4'b0011, 4'b0011, 16, 12);
    vecs[3] = mk(16'h0000, 4'b1111, 1'b1, 2'd2, {S0, S0, S0, S0}, 4'b0001, 4'b0001, 12, 8);
    vecs[4] = mk(16'h5E8F, 4'b1000, 1'b1, 2'd0, {S5, SE, S8, SF}, 4'b1111, 4'b1000, 4, 0);
    vecs[5] = mk(16'h0709, 4'b1111, 1'b1, 2'd3, {S0, S7, S0, S9}, 4'b0111, 4'b0111, 16, 12);
    vecs[6] = mk(16'h0006, 4'b0010, 1'b0, 2'd3, {S0, S0, S0, S6}, 4'b1111, 4'b0010, 16, 12);

    rst_n = 1'b0; data = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0; brightness = '0;
    #12;
    chk("rst_seg", seg, 7'h00);
    chk("rst_dp", dp, 1'b0);
    chk("rst_segen", segen, 4'h0);
    chk("rst_frame_tick", frame_tick, 1'b0);
    chk("rst_al_seg", seg_al, 7'h7F);
    chk("rst_al_dp", dp_al, 1'b1);
    chk("rst_al_segen", segen_al, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // Nothing lights before the first commit.
    pulse_load(vecs[0].data, vecs[0].dpi, vecs[0].blz, vecs[0].br);
    n_zero_err = 0;
    for (int n = 0; n < 200 && !frame_tick; n++) begin
      if (segen != 4'h0) n_zero_err++;
      adv(1);
    end
    chk("pre_commit_dark", n_zero_err, 0);
    chk("first_tick_pos", pos, 64);
    pos = 0;
    check_frame(vecs[0]);

    for (int i = 1; i < 7; i++) begin
      pulse_load(vecs[i].data, vecs[i].dpi, vecs[i].blz, vecs[i].br);
      wait_tick();
      check_frame(vecs[i]);
    end

    // Mid-frame load stays invisible until the next frame.
    pulse_load(16'h1234, 4'b0000, 1'b0, 2'd3);
    wait_tick();
    adv(20);
    pulse_load(16'hABCD, 4'b0000, 1'b0, 2'd3);
    adv(3);  chk("midload_d1", seg, S3);
    adv(16); chk("midload_d2", seg, S2);
    adv(16); chk("midload_d3", seg, S1);
    wait_tick();
    adv(8);  chk("next_d0", seg, SD);
    adv(16); chk("next_d1", seg, SC);
    adv(16); chk("next_d2", seg, SB);
    adv(16); chk("next_d3", seg, SA);
    $display("mid-frame load 1234->ABCD checked");

    // Load on the boundary cycle is deferred one full frame.
    adv(63 - pos);
    pulse_load(16'h7777, 4'b0000, 1'b0, 2'd3);
    chk("boundary_tick", frame_tick, 1'b1);
    pos = 0;
    adv(8);  chk("boundary_old", seg, SD);
    wait_tick();
    adv(8);  chk("boundary_new", seg, S7);
    $display("boundary load 7777 checked");

    // Repeated loads in one frame: last wins.
    pulse_load(16'h1111, 4'b0000, 1'b0, 2'd3);
    adv(20);
    pulse_load(16'h2222, 4'b0000, 1'b0, 2'd3);
    wait_tick();
    adv(8);  chk("lastwins_d0", seg, S2);
    adv(16); chk("lastwins_d1", seg, S2);
    $display("last-wins 1111/2222 checked");

    // Active-low instance with 8888.
    pulse_load(16'h8888, 4'b0000, 1'b0, 2'd3);
    wait_tick();
    adv(8);
    chk("al_seg", seg_al, 7'h00);
    chk("al_segen0", segen_al, 4'b1110);
    chk("al_dp", dp_al, 1'b1);
    adv(16);
    chk("al_segen1", segen_al, 4'b1101);
    $display("active-low 8888 checked");

    // Asynchronous reset mid-slot at index 2.
    adv(16);
    chk("pre_reset_segen", segen, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", seg, 7'h00);
    chk("async_dp", dp, 1'b0);
    chk("async_segen", segen, 4'h0);
    chk("async_al_seg", seg_al, 7'h7F);
    chk("async_al_segen", segen_al, 4'hF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first_tick = -1;
    n_zero_err = 0;
    for (int n = 1; n <= 140; n++) begin
      @(negedge clk);
      if (segen != 4'h0 || seg != 7'h00) n_zero_err++;
      if (frame_tick && first_tick < 0) first_tick = n;
    end
    chk("restart_tick", first_tick, 64);
    chk("post_reset_dark", n_zero_err, 0);
    $display("async reset at index 2 checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
